// File: rtl/alu_step_sequencer.sv
// Step-driven accumulator ALU: runs one fixed micro-op each time the program FSM's step count changes.
// Latency: 1 cycle from a newly sampled Count to updated Acc/flags/Result.
// No backpressure: every posedge samples Count; illegal steps set a sticky error and execute nothing.
module alu_step_sequencer #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [3:0]   Count,
  input  logic [W-1:0] Din,
  output logic [W-1:0] Acc,
  output logic [W-1:0] Result,
  output logic         ResultValid,
  output logic         Carry,
  output logic         Zero,
  output logic [1:0]   PassCount,
  output logic         Done,
  output logic         Err
);

  // Micro-op bound to each legal step number
  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_ADD   = 3'd1,
    OP_SHL   = 3'd2,
    OP_XOR   = 3'd3,
    OP_AND   = 3'd4,
    OP_OR    = 3'd5,
    OP_SUB   = 3'd6,
    OP_STORE = 3'd7
  } op_t;

  logic [3:0]   count_prev;
  logic         new_step;
  logic         exec;
  op_t          op;
  logic [W-1:0] acc_nxt;
  logic         carry_nxt;
  logic [W:0]   sum_ext;
  logic [W:0]   diff_ext;

  assign new_step = (Count != count_prev);
  assign exec     = new_step && !Count[3];
  assign op       = op_t'(Count[2:0]);
  assign sum_ext  = {1'b0, Acc} + {1'b0, Din};
  assign diff_ext = {1'b0, Acc} - {1'b0, Din};

  // Post-op accumulator and carry for the current step (used only when exec)
  always_comb begin
    acc_nxt   = Acc;
    carry_nxt = Carry;
    case (op)
      OP_LOAD: begin
        acc_nxt   = Din;
        carry_nxt = 1'b0;
      end
      OP_ADD: begin
        acc_nxt   = sum_ext[W-1:0];
        carry_nxt = sum_ext[W];
      end
      OP_SHL: begin
        acc_nxt   = {Acc[W-2:0], 1'b0};
        carry_nxt = Acc[W-1];
      end
      OP_XOR: acc_nxt = Acc ^ Din;
      OP_AND: acc_nxt = Acc & Din;
      OP_OR:  acc_nxt = Acc | Din;
      OP_SUB: begin
        // Borrow out of the W+1-bit difference is exactly Din > Acc
        acc_nxt   = diff_ext[W-1:0];
        carry_nxt = diff_ext[W];
      end
      default: begin
        acc_nxt   = Acc;
        carry_nxt = Carry;
      end
    endcase
  end

  // State update: step history, datapath, result capture and sticky status
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_prev  <= 4'hF;
      Acc         <= '0;
      Result      <= '0;
      ResultValid <= 1'b0;
      Carry       <= 1'b0;
      Zero        <= 1'b1;
      PassCount   <= 2'd0;
      Done        <= 1'b0;
      Err         <= 1'b0;
    end else begin
      count_prev  <= Count;
      ResultValid <= 1'b0;
      if (Count[3]) begin
        Err <= 1'b1;
      end
      // A repeated step 7 means the FSM has parked; STORE is not re-run
      if (Count == 4'd7 && count_prev == 4'd7) begin
        Done <= 1'b1;
      end
      if (exec) begin
        Acc   <= acc_nxt;
        Carry <= carry_nxt;
        Zero  <= (acc_nxt == '0);
        if (op == OP_STORE) begin
          Result      <= Acc;
          ResultValid <= 1'b1;
          if (PassCount != 2'd3) begin
            PassCount <= PassCount + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench for alu_step_sequencer with hand-computed expected values.
// Inputs change 1 time unit after posedge; outputs are checked 1 time unit after the following posedge.
// Covers reset state, two data patterns, borrow, illegal step, parking/Done and mid-pass reset.
module tb_alu_step_sequencer;

  logic       Clk;
  logic       Rst;
  logic [3:0] Count;
  logic [7:0] Din;
  logic [7:0] Acc;
  logic [7:0] Result;
  logic       ResultValid;
  logic       Carry;
  logic       Zero;
  logic [1:0] PassCount;
  logic       Done;
  logic       Err;

  int vectors;
  int miscompares;
  int rv_cnt;

  alu_step_sequencer #(.W(8)) dut (
    .Clk(Clk), .Rst(Rst), .Count(Count), .Din(Din),
    .Acc(Acc), .Result(Result), .ResultValid(ResultValid),
    .Carry(Carry), .Zero(Zero), .PassCount(PassCount),
    .Done(Done), .Err(Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus and return 1 unit after the sampling edge
  task automatic apply(input logic [3:0] c, input logic [7:0] d);
    Count = c;
    Din   = d;
    @(posedge Clk);
    #1;
    if (ResultValid === 1'b1) rv_cnt++;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    apply(4'd0, 8'h00);
    Rst = 1'b0;
    rv_cnt = 0;
  endtask

  task automatic chk_acc(input string tag, input logic [3:0] c, input logic [7:0] d,
                         input logic [7:0] exp_acc, input logic exp_c, input logic exp_z);
    apply(c, d);
    chk({tag, "_acc"}, 32'(Acc), 32'(exp_acc));
    chk({tag, "_carry"}, 32'(Carry), 32'(exp_c));
    chk({tag, "_zero"}, 32'(Zero), 32'(exp_z));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rv_cnt      = 0;
    Rst   = 1'b1;
    Count = 4'd0;
    Din   = 8'h00;
    @(posedge Clk);
    #1;

    // Reset state
    chk("rst_acc", 32'(Acc), 32'h00);
    chk("rst_result", 32'(Result), 32'h00);
    chk("rst_rv", 32'(ResultValid), 32'h0);
    chk("rst_carry", 32'(Carry), 32'h0);
    chk("rst_zero", 32'(Zero), 32'h1);
    chk("rst_pass", 32'(PassCount), 32'h0);
    chk("rst_done", 32'(Done), 32'h0);
    chk("rst_err", 32'(Err), 32'h0);
    Rst = 1'b0;
    rv_cnt = 0;

    // Pass with Din=5
    chk_acc("p5_s0", 4'd0, 8'h05, 8'h05, 1'b0, 1'b0);
    chk_acc("p5_s1", 4'd1, 8'h05, 8'h0A, 1'b0, 1'b0);
    chk_acc("p5_s2", 4'd2, 8'h05, 8'h14, 1'b0, 1'b0);
    chk_acc("p5_s3", 4'd3, 8'h05, 8'h11, 1'b0, 1'b0);
    chk_acc("p5_s4", 4'd4, 8'h05, 8'h01, 1'b0, 1'b0);
    chk_acc("p5_s5", 4'd5, 8'h05, 8'h05, 1'b0, 1'b0);
    chk_acc("p5_s6", 4'd6, 8'h05, 8'h00, 1'b0, 1'b1);
    apply(4'd7, 8'h05);
    chk("p5_rv", 32'(ResultValid), 32'h1);
    chk("p5_result", 32'(Result), 32'h00);
    chk("p5_pass", 32'(PassCount), 32'h1);
    apply(4'd0, 8'h33);
    chk("p5_rv_once", 32'(rv_cnt), 32'd1);
    chk("p5_rv_low", 32'(ResultValid), 32'h0);

    // Pass with Din=0x90: carry out of ADD, shift-out of SHL
    do_reset();
    chk_acc("p90_s0", 4'd0, 8'h90, 8'h90, 1'b0, 1'b0);
    chk_acc("p90_s1", 4'd1, 8'h90, 8'h20, 1'b1, 1'b0);
    chk_acc("p90_s2", 4'd2, 8'h90, 8'h40, 1'b0, 1'b0);
    chk_acc("p90_s3", 4'd3, 8'h90, 8'hD0, 1'b0, 1'b0);
    chk_acc("p90_s4", 4'd4, 8'h90, 8'h90, 1'b0, 1'b0);
    chk_acc("p90_s5", 4'd5, 8'h90, 8'h90, 1'b0, 1'b0);
    chk_acc("p90_s6", 4'd6, 8'h90, 8'h00, 1'b0, 1'b1);
    // Din change with no new step has no effect
    chk_acc("p90_hold", 4'd6, 8'hFF, 8'h00, 1'b0, 1'b1);
    apply(4'd7, 8'h90);
    chk("p90_result", 32'(Result), 32'h00);

    // Borrow: 01,02,04,05,01,01 then 01-02 wraps to FF
    do_reset();
    apply(4'd0, 8'h01);
    apply(4'd1, 8'h01);
    apply(4'd2, 8'h01);
    apply(4'd3, 8'h01);
    chk_acc("sub_s4", 4'd4, 8'h01, 8'h01, 1'b0, 1'b0);
    apply(4'd5, 8'h01);
    chk_acc("sub_s6", 4'd6, 8'h02, 8'hFF, 1'b1, 1'b0);
    apply(4'd7, 8'h00);
    chk("sub_result", 32'(Result), 32'hFF);

    // Illegal step mid-pass
    do_reset();
    apply(4'd0, 8'h05);
    apply(4'd1, 8'h05);
    chk_acc("err_s2", 4'd2, 8'h05, 8'h14, 1'b0, 1'b0);
    chk_acc("err_ill", 4'd9, 8'hFF, 8'h14, 1'b0, 1'b0);
    chk("err_set", 32'(Err), 32'h1);
    chk_acc("err_s3", 4'd3, 8'h05, 8'h11, 1'b0, 1'b0);
    chk("err_sticky", 32'(Err), 32'h1);

    // Three full passes then park at 7
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int s = 0; s < 7; s++) apply(4'(s), 8'h05);
      apply(4'd7, 8'h05);
      chk("run_done_early", 32'(Done), 32'h0);
    end
    chk("run_rv3", 32'(rv_cnt), 32'd3);
    chk("run_pass", 32'(PassCount), 32'd3);
    apply(4'd7, 8'h05);
    chk("run_done_hold2", 32'(Done), 32'h1);
    for (int h = 0; h < 4; h++) apply(4'd7, 8'h05);
    chk("run_rv_after", 32'(rv_cnt), 32'd3);
    chk("run_done_sticky", 32'(Done), 32'h1);
    chk("run_pass_sat", 32'(PassCount), 32'd3);
    // A fourth pass must not push PassCount past 3
    for (int s = 0; s < 8; s++) apply(4'(s), 8'h05);
    chk("run_pass_sat4", 32'(PassCount), 32'd3);

    // Reset during step 4 of pass 2
    do_reset();
    for (int s = 0; s < 8; s++) apply(4'(s), 8'h05);
    for (int s = 0; s < 4; s++) apply(4'(s), 8'h05);
    Rst = 1'b1;
    apply(4'd4, 8'h05);
    Rst = 1'b0;
    chk("mrst_acc", 32'(Acc), 32'h00);
    chk("mrst_pass", 32'(PassCount), 32'h0);
    chk("mrst_done", 32'(Done), 32'h0);
    chk("mrst_zero", 32'(Zero), 32'h1);
    chk("mrst_result", 32'(Result), 32'h00);
    chk_acc("mrst_load", 4'd0, 8'h3C, 8'h3C, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_step_sequencer.md
Name: alu_step_sequencer

Overview:
- Downstream consumer of the main program FSM's 4-bit step count (0..7, three passes, then holds at 7).
- Detects each new step and executes the fixed micro-op bound to that step on an internal accumulator, using external operand Din.
- On step 7 it latches the accumulator into Result, counts completed passes, and flags Done once the FSM parks at 7.

Parameters:
W, 8, datapath width of Din, Acc and Result (minimum 2)

Ports:
Clk  input  1  clock, all state updates on posedge
Rst  input  1  synchronous, active-high reset
Count  input  4  step number from the program FSM; legal 0..7
Din  input  W  operand for LOAD/ADD/XOR/AND/OR/SUB steps
Acc  output  W  accumulator register
Result  output  W  accumulator value captured at step 7
ResultValid  output  1  one-cycle pulse, Result just updated
Carry  output  1  carry/borrow/shift-out of last arithmetic or shift op
Zero  output  1  Acc==0 after last executed op
PassCount  output  2  completed step-7 executions, saturates at 3
Done  output  1  sticky; FSM has parked at step 7
Err  output  1  sticky; illegal Count (8..15) was sampled

Behaviour:
- Reset (Rst=1 at posedge): Acc=0, Result=0, ResultValid=0, Carry=0, Zero=1, PassCount=0, Done=0, Err=0, CountPrev=4'hF.
  - Reset wins over every other event, including mid-pass; the next Count sampled after reset counts as a new step.
- Step detect: NewStep = (Count != CountPrev). CountPrev<=Count every non-reset posedge.
- Execution:
  - Ops execute only at a posedge with NewStep=1 and Count<=7.
  - Latency: 1 cycle. Acc/flags reflect step k at the posedge where Count==k is first sampled.
  - Otherwise Acc, Carry and Zero hold.
- Step table (arithmetic modulo 2^W, Carry computed on W+1 bits):
  - 0 LOAD: Acc=Din; Carry=0
  - 1 ADD: {Carry,Acc}=Acc+Din
  - 2 SHL: Carry=Acc[W-1]; Acc=Acc<<1, LSB 0
  - 3 XOR: Acc=Acc^Din; Carry unchanged
  - 4 AND: Acc=Acc&Din; Carry unchanged
  - 5 OR: Acc=Acc|Din; Carry unchanged
  - 6 SUB: Acc=Acc-Din; Carry=1 iff Din>Acc (borrow)
  - 7 STORE: Result=Acc; ResultValid=1 for exactly this cycle; Acc and Carry unchanged; PassCount=PassCount+1, saturating at 3
- Zero: updated with every executed op from the post-op Acc value.
- Done:
  - Set at a posedge with Count==7 and CountPrev==7 (step 7 repeated, no new step).
  - Stays set until reset. No re-execution of STORE while held.
- Err: set at any posedge with Count>7.
  - No op executes for the illegal value; CountPrev still updates.
  - Err is sticky until reset.
- Out-of-order or skipped steps: no ordering check; each new legal Count executes its own op.
- Din is sampled only at an executing edge. Din changes between steps have no effect.

Test Plan:
- Reset, FSM drives 0..7 once, Din=5 -> Acc sequence 05,0A,14,11,01,05,00; Zero=1 after step 6, Carry=0; Result=00; one ResultValid pulse; PassCount=1.
- Din=0x90, one pass -> step1 Acc=20 Carry=1; step2 Acc=40 Carry=0; step3 D0; step4 90; step5 90; step6 00 Carry=0; Result=00.
- Full FSM run (3 passes, then hold at 7 for 5 cycles) -> exactly 3 ResultValid pulses; PassCount=3; Done rises on the 2nd cycle Count==7 is held; no further ResultValid.
- Din=0x01 at step 0, Din=0x02 at step 6 -> SUB sets Carry=1 (borrow), Acc wraps to the mod-256 value, Zero=0.
- Drive Count=9 for one cycle mid-pass -> Err=1 sticky; Acc unchanged that cycle; next legal step executes normally.
- Assert Rst during step 4 of pass 2 -> all outputs at reset values next cycle; PassCount=0, Done=0; subsequent Count=0 executes LOAD.
